// File: rtl/filter_ctrl_pkg.sv
// Shared types and constants for the trapezoidal filter controller.
package p_filter_ctrl;
  localparam int K_W      = 8;
  localparam int M_W      = 16;
  localparam int MAX_WIN  = 128;
  localparam int FILT_LAT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_SETTLE,
    ST_RUN
  } state_t;

  typedef struct packed {
    logic [K_W-1:0] k;
    logic [K_W-1:0] l;
    logic [M_W-1:0] m;
  } cfg_t;

  // The filter window must be non-empty, rise no longer than it lasts, and fit the delay line.
  function automatic logic cfg_ok(cfg_t c);
    return (c.k != '0) && (c.k <= c.l) && ((int'(c.k) + int'(c.l)) <= MAX_WIN);
  endfunction
endpackage

// File: rtl/package_settings.sv
// Project-wide data widths shared by the ADC processing chain.
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
endpackage

// File: rtl/filter_ctrl_cfg.sv
// Config handshake, validation, pending slot and active filter parameters.
module filter_ctrl_cfg
  import p_filter_ctrl::*;
#(
  parameter int DEF_K = 4,
  parameter int DEF_L = 12,
  parameter int DEF_M = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cfg_valid,
  input  logic [K_W-1:0] cfg_k,
  input  logic [K_W-1:0] cfg_l,
  input  logic [M_W-1:0] cfg_m,
  input  logic           direct_apply,
  input  logic           ready_state,
  output logic           wr_ok,
  output logic           pending,
  output logic           cfg_ready,
  output logic           cfg_err,
  output cfg_t           active
);

  cfg_t req;
  cfg_t active_q, active_d;
  cfg_t pend_q, pend_d;
  logic pend_v_q, pend_v_d;
  logic ready_q, ready_d;
  logic err_q, err_d;
  logic accept;
  logic req_ok;

  assign req.k   = cfg_k;
  assign req.l   = cfg_l;
  assign req.m   = cfg_m;
  assign accept  = cfg_valid && ready_q;
  assign req_ok  = cfg_ok(req);
  assign wr_ok   = accept && req_ok;

  always_comb begin
    active_d = active_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    err_d    = accept && !req_ok;
    // A parked config is always consumed the cycle after it lands; the FSM flushes in step.
    if (pend_v_q) begin
      active_d = pend_q;
      pend_v_d = 1'b0;
    end else if (wr_ok) begin
      if (direct_apply) begin
        active_d = req;
      end else begin
        pend_d   = req;
        pend_v_d = 1'b1;
      end
    end
    ready_d = ready_state && !pend_v_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q.k <= K_W'(DEF_K);
      active_q.l <= K_W'(DEF_L);
      active_q.m <= M_W'(DEF_M);
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      active_q <= active_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
    end
  end

  assign pending   = pend_v_q;
  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;
  assign active    = active_q;

endmodule

// File: rtl/filter_ctrl.sv
// Run-time sequencer for the trapezoidal shaping filter: flush, settle, then gate samples out.
module filter_ctrl
  import p_filter_ctrl::*, package_settings::*;
#(
  parameter int DEF_K     = 4,
  parameter int DEF_L     = 12,
  parameter int DEF_M     = 64,
  parameter int FLUSH_CYC = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [K_W-1:0]              cfg_k,
  input  logic [K_W-1:0]              cfg_l,
  input  logic [M_W-1:0]              cfg_m,
  output logic                        cfg_err,
  input  logic                        start,
  input  logic                        stop,
  output logic                        filt_run,
  output logic [K_W-1:0]              filt_k,
  output logic [K_W-1:0]              filt_l,
  output logic [M_W-1:0]              filt_m,
  input  logic [SIZE_FILTER_DATA-1:0] filt_data,
  output logic [SIZE_FILTER_DATA-1:0] out_data,
  output logic                        out_valid,
  output logic                        busy,
  output logic [31:0]                 sample_cnt
);

  localparam int CNT_W = K_W + 2;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        filt_run_q, filt_run_d;
  logic                        out_valid_q, out_valid_d;
  logic                        busy_q, busy_d;
  logic [SIZE_FILTER_DATA-1:0] out_data_q, out_data_d;
  logic [31:0]                 sample_cnt_q, sample_cnt_d;
  logic                        wr_ok, pending, direct_apply, ready_state;
  cfg_t                        active;
  logic [CNT_W-1:0]            settle_len;

  assign direct_apply = (state_q == ST_IDLE) || stop;
  assign ready_state  = (state_d == ST_IDLE) || (state_d == ST_RUN);
  assign settle_len   = CNT_W'(active.k) + CNT_W'(active.l) + CNT_W'(FILT_LAT - 1);

  filter_ctrl_cfg #(
    .DEF_K(DEF_K),
    .DEF_L(DEF_L),
    .DEF_M(DEF_M)
  ) u_cfg (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_k        (cfg_k),
    .cfg_l        (cfg_l),
    .cfg_m        (cfg_m),
    .direct_apply (direct_apply),
    .ready_state  (ready_state),
    .wr_ok        (wr_ok),
    .pending      (pending),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .active       (active)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        // A config landing in IDLE takes the cycle; start is ignored alongside it.
        ST_IDLE: begin
          if (start && !wr_ok) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYC - 1);
          end
        end
        ST_FLUSH: begin
          if (cnt_q == '0) begin
            state_d = ST_SETTLE;
            cnt_d   = settle_len;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (pending) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYC - 1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    filt_run_d  = (state_d == ST_SETTLE) || (state_d == ST_RUN);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_q == ST_RUN) && !stop;
    out_data_d  = out_valid_d ? filt_data : '0;

    if ((state_q != ST_RUN) && (state_d == ST_RUN)) begin
      sample_cnt_d = '0;
    end else if (out_valid_d) begin
      sample_cnt_d = sample_cnt_q + 32'd1;
    end else begin
      sample_cnt_d = sample_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      filt_run_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      filt_run_q   <= filt_run_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      busy_q       <= busy_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign filt_run   = filt_run_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign busy       = busy_q;
  assign sample_cnt = sample_cnt_q;
  assign filt_k     = active.k;
  assign filt_l     = active.l;
  assign filt_m     = active.m;

endmodule
